// File: rtl/ahblite_slavemux_if.sv
// rtl/ahblite_slavemux_if.sv - AHB-Lite slave-mux bus bundle: master-side controls, per-port slave returns, muxed response
interface ahblite_slavemux_if;
    logic        HSEL_M;
    logic [1:0]  HTRANS;
    logic        P0_HSEL;
    logic        P1_HSEL;
    logic        P2_HSEL;
    logic        P3_HSEL;
    logic        P0_HREADYOUT;
    logic        P1_HREADYOUT;
    logic        P2_HREADYOUT;
    logic        P3_HREADYOUT;
    logic        P0_HRESP;
    logic        P1_HRESP;
    logic        P2_HRESP;
    logic        P3_HRESP;
    logic [31:0] P0_HRDATA;
    logic [31:0] P1_HRDATA;
    logic [31:0] P2_HRDATA;
    logic [31:0] P3_HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    // The mux itself: consumes selects and slave returns, produces the bus response
    modport slave (
        input  HSEL_M, HTRANS,
        input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        output HREADY, HRESP, HRDATA
    );

    // The bus side driving the mux: master, decoder and slaves
    modport master (
        output HSEL_M, HTRANS,
        output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        input  HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_slavemux.sv
// rtl/ahblite_slavemux.sv - AHB-Lite 4-port response mux with default ERROR slave; optional watchdog via AHBLITE_SLAVEMUX_TIMEOUT_EN
module ahblite_slavemux #(
    parameter bit          Port0_en       = 1'b1,
    parameter bit          Port1_en       = 1'b1,
    parameter bit          Port2_en       = 1'b1,
    parameter bit          Port3_en       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic HCLK,
    input  logic HRESET,
    ahblite_slavemux_if.slave bus
);

    localparam logic [3:0] EN_MASK = {Port3_en, Port2_en, Port1_en, Port0_en};

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ahblite_slavemux: TIMEOUT_CYCLES must be within 2..65535");
    end

`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ERR1, ST_ERR2, ST_TO1, ST_TO2} state_t;
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic        dflt_req_q, dflt_req_d;

    logic [3:0]  sel_raw;
    logic [3:0]  sel_masked;
    logic [3:0]  sel_lowest;
    logic        dflt_hit;
    logic        sel_ready;
    logic        sel_resp;
    logic [31:0] sel_rdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        stall;
    logic        timeout_hit;
`endif

    // Address-phase decode: mask disabled ports, keep the lowest-index hit, flag default-slave accesses
    always_comb begin
        sel_raw    = {bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
        sel_masked = sel_raw & EN_MASK;
        sel_lowest = sel_masked & (~sel_masked + 4'd1);
        dflt_hit   = bus.HSEL_M && bus.HTRANS[1] && (sel_masked == 4'd0);
    end

    // Return path of the port captured for the current data phase; other ports are never looked at
    always_comb begin
        sel_ready = 1'b1;
        sel_resp  = 1'b0;
        sel_rdata = 32'd0;
        if (sel_q[0]) begin
            sel_ready = bus.P0_HREADYOUT;
            sel_resp  = bus.P0_HRESP;
            sel_rdata = bus.P0_HRDATA;
        end else if (sel_q[1]) begin
            sel_ready = bus.P1_HREADYOUT;
            sel_resp  = bus.P1_HRESP;
            sel_rdata = bus.P1_HRDATA;
        end else if (sel_q[2]) begin
            sel_ready = bus.P2_HREADYOUT;
            sel_resp  = bus.P2_HRESP;
            sel_rdata = bus.P2_HRDATA;
        end else if (sel_q[3]) begin
            sel_ready = bus.P3_HREADYOUT;
            sel_resp  = bus.P3_HRESP;
            sel_rdata = bus.P3_HRDATA;
        end
    end

`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
    // Watchdog: count wait states of the selected slave; any completed phase clears it
    always_comb begin
        stall       = (state_q == ST_IDLE) && (sel_q != 4'd0) && !sel_ready;
        cnt_d       = stall ? cnt_q + 16'd1 : 16'd0;
        timeout_hit = stall && (cnt_q == TO_LIMIT);
    end
`endif

    // Output decode: ERROR states override the mux; an empty data phase answers OKAY with zero data
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'd0;
        case (state_q)
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
            ST_TO1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_TO2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
`endif
            default: begin
                if (sel_q != 4'd0 && !dflt_req_q) begin
                    hready = sel_ready;
                    hresp  = sel_resp;
                    hrdata = sel_rdata;
                end
            end
        endcase
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;

    // Next state: a default access captured on a ready edge starts the two-cycle ERROR straight away
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hready && dflt_hit) begin
                    state_d = ST_ERR1;
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ST_TO1;
`endif
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = dflt_hit ? ST_ERR1 : ST_IDLE;
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
            ST_TO1:  state_d = ST_TO2;
            ST_TO2:  state_d = dflt_hit ? ST_ERR1 : ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Address-phase capture only on ready edges; a timed-out slave is dropped before TO2
    always_comb begin
        sel_d      = sel_q;
        dflt_req_d = dflt_req_q;
        if (hready) begin
            sel_d      = sel_lowest;
            dflt_req_d = dflt_hit;
        end
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
        if (state_q == ST_TO1) begin
            sel_d = 4'd0;
        end
`endif
    end

    // State register with synchronous active-high reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            sel_q      <= 4'd0;
            dflt_req_q <= 1'b0;
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            dflt_req_q <= dflt_req_d;
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule
